// File: rtl/sat_alu_pkg.sv
// Shared op encodings and signed-range helpers for the saturating add/sub unit.
package sat_alu_pkg;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_PADDSB = 2'b10;
    localparam logic [1:0] OP_ADDW   = 2'b11;

    localparam int MAX_W = 64;

    // Bit patterns of the most positive / most negative w-bit value, right-aligned; truncate at the use site.
    function automatic logic [MAX_W-1:0] smax(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] smin(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sat_alu_pipe_lane.sv
// One LANE-bit slice: ripple add with optional carry break, signed overflow and lane-local saturation.
module sat_lane_add #(
    parameter int LANE = 4
) (
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    input  logic            cin,
    input  logic            brk,
    output logic [LANE-1:0] sum,
    output logic            cout,
    output logic            ovf,
    output logic [LANE-1:0] sat
);
    import sat_alu_pkg::*;

    localparam logic [LANE-1:0] LMAX = LANE'(smax(LANE));
    localparam logic [LANE-1:0] LMIN = LANE'(smin(LANE));

    logic [LANE:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin};
    assign sum  = full[LANE-1:0];
    assign cout = full[LANE] & ~brk;
    // Same-sign operands producing an opposite-sign result; valid with any carry-in.
    assign ovf  = (a[LANE-1] == b[LANE-1]) && (sum[LANE-1] != a[LANE-1]);
    assign sat  = ovf ? (a[LANE-1] ? LMIN : LMAX) : sum;

endmodule

// File: rtl/sat_alu_pipe.sv
// Two-stage saturating add/sub/PADDSB/wrapping-add unit with valid/ready flow control and a saturation counter.
module sat_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_v,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);
    import sat_alu_pkg::*;

    localparam int NL = WIDTH / LANE;
    localparam logic [WIDTH-1:0] WMAX = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] WMIN = WIDTH'(smin(WIDTH));

    logic             s1_v, s2_v, adv1, adv2;
    logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
    logic [1:0]       s1_op_reg;
    logic             s2_sat_reg;

    logic [WIDTH-1:0] b_eff, raw_sum, lane_sat, sum_next;
    logic [NL-1:0]    lane_ovf;
    logic [NL:0]      carry;
    logic             lane_brk, v_next, sat_next, carry_unused;

    assign adv2      = !s2_v || out_ready;
    assign adv1      = !s1_v || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_v;

    // SUB is A + ~B + 1: invert B and inject the +1 as the lane-0 carry-in.
    assign b_eff        = (s1_op_reg == OP_SUB) ? ~s1_b_reg : s1_b_reg;
    assign carry[0]     = (s1_op_reg == OP_SUB);
    assign lane_brk     = (s1_op_reg == OP_PADDSB);
    assign carry_unused = carry[NL];

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            sat_lane_add #(.LANE(LANE)) u_lane (
                .a    (s1_a_reg[gi*LANE +: LANE]),
                .b    (b_eff[gi*LANE +: LANE]),
                .cin  (carry[gi]),
                .brk  (lane_brk),
                .sum  (raw_sum[gi*LANE +: LANE]),
                .cout (carry[gi+1]),
                .ovf  (lane_ovf[gi]),
                .sat  (lane_sat[gi*LANE +: LANE])
            );
        end
    endgenerate

    // With the chain unbroken, the top lane's overflow is the whole-word signed overflow.
    always_comb begin
        sum_next = raw_sum;
        v_next   = lane_ovf[NL-1];
        sat_next = 1'b0;
        case (s1_op_reg)
            OP_ADD, OP_SUB: begin
                if (lane_ovf[NL-1]) begin
                    sum_next = s1_a_reg[WIDTH-1] ? WMIN : WMAX;
                end
                sat_next = lane_ovf[NL-1];
            end
            OP_PADDSB: begin
                sum_next = lane_sat;
                v_next   = |lane_ovf;
                sat_next = |lane_ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            out_sum    <= '0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
            s2_sat_reg <= 1'b0;
        end else begin
            if (adv1) begin
                s1_v <= in_valid;
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_sum    <= sum_next;
                    out_n      <= sum_next[WIDTH-1];
                    out_z      <= (sum_next == '0);
                    out_v      <= v_next;
                    s2_sat_reg <= sat_next;
                end
            end
        end
    end

    // Operand registers carry no reset; s1_v qualifies them.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_a_reg  <= in_a;
            s1_b_reg  <= in_b;
            s1_op_reg <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_cnt <= '0;
        end else if (s2_v && out_ready && s2_sat_reg && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sat_alu_pipe.sv
// Scoreboard bench for sat_alu_pipe: expected beats queued at input handshake, compared at output handshake.
module tb_sat_alu_pipe;
    import sat_alu_pkg::*;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int CW = 8;
    localparam int SMAXI = 2 ** (W - 1) - 1;
    localparam int SMINI = -(2 ** (W - 1));
    localparam int LMAXI = 2 ** (L - 1) - 1;
    localparam int LMINI = -(2 ** (L - 1));

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic          out_n, out_z, out_v;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic [1:0]    in_op;
    logic [CW-1:0] sat_cnt;

    always #5 clk = ~clk;

    sat_alu_pipe #(.WIDTH(W), .LANE(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_n(out_n), .out_z(out_z),
        .out_v(out_v), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic n;
        logic z;
        logic v;
        logic sat;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t pexp_q[$];
    int errors = 0, checks = 0, occ = 0, unexpected = 0, pushed = 0, cnt_exp = 0;

    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        beat_t r;
        int s, ls;
        r = '0;
        if (op == OP_PADDSB) begin
            for (int k = 0; k < W / L; k++) begin
                ls = int'($signed(a[k*L +: L])) + int'($signed(b[k*L +: L]));
                if (ls > LMAXI) begin ls = LMAXI; r.v = 1'b1; end
                else if (ls < LMINI) begin ls = LMINI; r.v = 1'b1; end
                r.sum[k*L +: L] = ls[L-1:0];
            end
            r.sat = r.v;
        end else begin
            s = (op == OP_SUB) ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
            r.v = (s > SMAXI) || (s < SMINI);
            if (op != OP_ADDW) begin
                r.sat = r.v;
                if (s > SMAXI) s = SMAXI;
                else if (s < SMINI) s = SMINI;
            end
            r.sum = s[W-1:0];
        end
        r.n = r.sum[W-1];
        r.z = (r.sum == '0);
        return r;
    endfunction

    // One clock: record handshakes seen just before the edge, then return 1 ns after it.
    task automatic tick();
        beat_t e, g;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            occ = 0;
            cnt_exp = 0;
        end else begin
            if (out_valid && out_ready) begin
                g = '{sum: out_sum, n: out_n, z: out_z, v: out_v, sat: 1'b0};
                if (exp_q.size() == 0) begin
                    unexpected++;
                end else begin
                    e = exp_q.pop_front();
                    got_q.push_back(g);
                    pexp_q.push_back(e);
                    if (!cnt_clr && e.sat && cnt_exp < 2 ** CW - 1) cnt_exp++;
                end
                occ--;
            end
            if (cnt_clr) cnt_exp = 0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_op));
                occ++;
                pushed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        int n, p;
        n = 0;
        p = pushed;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        while (pushed == p && n < 20) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (pushed == p) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat a=%h b=%h not accepted within %0d cycles", a, b, n);
        end
    endtask

    task automatic drain(input int want);
        int n;
        n = 0;
        while (got_q.size() < want && n < 50) begin
            tick();
            n++;
        end
        if (got_q.size() < want) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats, required %0d", got_q.size(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_a = '0; in_b = '0; in_op = OP_ADD;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, out_sum, out_n, out_z, out_v} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h nzv=%b%b%b, required all zero",
                     out_valid, out_sum, out_n, out_z, out_v);
        end
        checks++;
        if (sat_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d required 0", sat_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(16'd20000, 16'd10000, OP_ADD);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: out_valid=%b one cycle after handshake, required 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_sum, out_n, out_z, out_v} !== {1'b1, 16'd30000, 3'b000}) begin
            errors++;
            $display("FAIL latency_result: got valid=%b sum=%0d nzv=%b%b%b, required 1 30000 000",
                     out_valid, out_sum, out_n, out_z, out_v);
        end
        drain(1);
        void'(got_q.pop_front());
        void'(pexp_q.pop_front());
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[10], vb[10], vsum[10];
        logic [1:0]   vop[10];
        logic         vv[10];
        beat_t        g, e;
        va   = '{16'd20000, 16'd20000, 16'h0000, 16'd5, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h7321, 16'h8888, 16'h1234};
        vb   = '{16'd10000, 16'd10000, 16'h8000, 16'd5, 16'h0064, 16'hFB2E, 16'h0064, 16'h1111, 16'h8888, 16'h1111};
        vop  = '{OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_ADD, OP_ADD, OP_ADDW, OP_PADDSB, OP_PADDSB, OP_PADDSB};
        vsum = '{16'd30000, 16'd10000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h8063, 16'h7432, 16'h8888, 16'h2345};
        vv   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(va[i], vb[i], vop[i]);
        drain(10);
        for (int i = 0; i < 10 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = pexp_q.pop_front();
            checks++;
            if (g.sum !== vsum[i] || g.v !== vv[i] || g.n !== vsum[i][W-1] || g.z !== (vsum[i] == '0)) begin
                errors++;
                $display("FAIL vector_%0d: got sum=%h nzv=%b%b%b, required sum=%h v=%b",
                         i, g.sum, g.n, g.z, g.v, vsum[i], vv[i]);
            end
            checks++;
            if ({g.sum, g.n, g.z, g.v} !== {e.sum, e.n, e.z, e.v}) begin
                errors++;
                $display("FAIL vector_model_%0d: got %h/%b%b%b, required %h/%b%b%b",
                         i, g.sum, g.n, g.z, g.v, e.sum, e.n, e.z, e.v);
            end
        end
        checks++;
        if (sat_cnt !== CW'(cnt_exp)) begin
            errors++; $display("FAIL vector_cnt: got %0d required %0d", sat_cnt, cnt_exp);
        end
    endtask

    task automatic test_counter();
        int n;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        send(16'h7FFF, 16'h0001, OP_ADD);
        send(16'h8000, 16'h0001, OP_SUB);
        send(16'h7777, 16'h1111, OP_PADDSB);
        drain(3);
        while (got_q.size() > 0) begin
            void'(got_q.pop_front());
            void'(pexp_q.pop_front());
        end
        checks++;
        if (sat_cnt !== 8'd3) begin
            errors++; $display("FAIL cnt_three: got %0d required 3", sat_cnt);
        end
        out_ready = 1'b0;
        send(16'h7FFF, 16'h7FFF, OP_ADD);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL cnt_clr_beat: got %0d beats, required 1", got_q.size());
        end
        checks++;
        if (sat_cnt !== 8'd0) begin
            errors++; $display("FAIL cnt_clr_wins: got %0d required 0", sat_cnt);
        end
        while (got_q.size() > 0) begin
            void'(got_q.pop_front());
            void'(pexp_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ba[6], bb[6], prev_sum;
        logic [1:0]   bop[6];
        logic         exp_ir, prev_stall;
        int           sent, p;
        beat_t        g, e;
        for (int i = 0; i < 6; i++) begin
            ba[i]  = W'($urandom);
            bb[i]  = W'($urandom);
            bop[i] = 2'(i % 4);
        end
        sent = 0;
        prev_stall = 1'b0;
        prev_sum = '0;
        for (int cyc = 0; cyc < 60 && got_q.size() < 6; cyc++) begin
            out_ready = (cyc % 2 == 1);
            if (sent < 6) begin
                in_valid = 1'b1; in_a = ba[sent]; in_b = bb[sent]; in_op = bop[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ir = !(occ == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_ir) begin
                errors++;
                $display("FAIL b2b_in_ready: cycle %0d got %b required %b (occupancy %0d)", cyc, in_ready, exp_ir, occ);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
                    errors++;
                    $display("FAIL b2b_stall_hold: cycle %0d got valid=%b sum=%h, required 1 %h",
                             cyc, out_valid, out_sum, prev_sum);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum = out_sum;
            p = pushed;
            tick();
            if (pushed != p) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got_q.size() !== 6) begin
            errors++; $display("FAIL b2b_count: got %0d beats, required 6", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = pexp_q.pop_front();
            checks++;
            if ({g.sum, g.n, g.z, g.v} !== {e.sum, e.n, e.z, e.v}) begin
                errors++;
                $display("FAIL b2b_beat_%0d: got %h/%b%b%b, required %h/%b%b%b",
                         i, g.sum, g.n, g.z, g.v, e.sum, e.n, e.z, e.v);
            end
        end
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b1;
        send(16'h7FFF, 16'h0100, OP_ADD);
        drain(1);
        void'(got_q.pop_front());
        void'(pexp_q.pop_front());
        checks++;
        if (sat_cnt !== CW'(cnt_exp) || cnt_exp == 0) begin
            errors++; $display("FAIL flight_cnt_before: got %0d required %0d (nonzero)", sat_cnt, cnt_exp);
        end
        out_ready = 1'b0;
        send(16'h7FFF, 16'h7FFF, OP_ADD);
        send(16'h1234, 16'h1111, OP_SUB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== '0) begin
            errors++;
            $display("FAIL flight_reset: got valid=%b cnt=%0d, required 0 0", out_valid, sat_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (got_q.size() !== 0 || unexpected !== 0) begin
            errors++;
            $display("FAIL flight_stale: got %0d stale beats, required 0", got_q.size() + unexpected);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_counter();
        test_back_to_back();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
